// File: rtl/grf_scoreboard_if.sv
// Issue/retire/status bundle between decode, write-back and the GPR busy scoreboard.
// master = pipeline side (decode + write-back), slave = scoreboard.
interface grf_scoreboard_if #(
    parameter int TOT_W = 7
);
    logic             pause;
    logic             iss_valid;
    logic             iss_ready;
    logic [4:0]       iss_dst;
    logic [4:0]       iss_rs;
    logic [4:0]       iss_rt;
    logic             iss_use_rs;
    logic             iss_use_rt;
    logic             ret_we;
    logic [4:0]       ret_adr;
    logic             stall;
    logic [31:0]      busy_mask;
    logic [TOT_W-1:0] outstanding;
    logic             err;

    modport master (
        output pause, iss_valid, iss_dst, iss_rs, iss_rt, iss_use_rs, iss_use_rt,
        output ret_we, ret_adr,
        input  iss_ready, stall, busy_mask, outstanding, err
    );

    modport slave (
        input  pause, iss_valid, iss_dst, iss_rs, iss_rt, iss_use_rs, iss_use_rt,
        input  ret_we, ret_adr,
        output iss_ready, stall, busy_mask, outstanding, err
    );
endinterface

// File: rtl/grf_scoreboard.sv
// GPR busy scoreboard: per-register pending-write counters set at issue, cleared at write-back.
// Optional macro GRF_SCB_ERR_EN adds a sticky underflow error flag (err tied low otherwise).
module grf_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int TOT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    grf_scoreboard_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [TOT_W-1:0] outstanding_q;
    logic [TOT_W-1:0] outstanding_nxt;
    logic [NREG-1:0]  busy;

    logic ret_fire;
    logic ret_valid;
    logic iss_fire;
    logic same_reg;
    logic hazard_rs;
    logic hazard_rt;
    logic dst_full;
    logic iss_ready;

    assign ret_fire  = bus.ret_we & ~bus.pause & (bus.ret_adr != 5'd0);
    assign ret_valid = ret_fire & (cnt[bus.ret_adr] != '0);

    // A retire of the last pending write forwards through the register file, so it is not a hazard.
    assign hazard_rs = bus.iss_use_rs & (bus.iss_rs != 5'd0) & (cnt[bus.iss_rs] != '0)
                     & ~(ret_fire & (bus.ret_adr == bus.iss_rs) & (cnt[bus.iss_rs] == CNT_W'(1)));
    assign hazard_rt = bus.iss_use_rt & (bus.iss_rt != 5'd0) & (cnt[bus.iss_rt] != '0)
                     & ~(ret_fire & (bus.ret_adr == bus.iss_rt) & (cnt[bus.iss_rt] == CNT_W'(1)));
    assign dst_full  = (bus.iss_dst != 5'd0) & (cnt[bus.iss_dst] == CNT_MAX)
                     & ~(ret_fire & (bus.ret_adr == bus.iss_dst));

    assign iss_ready = ~bus.pause & ~hazard_rs & ~hazard_rt & ~dst_full;
    assign iss_fire  = bus.iss_valid & iss_ready & (bus.iss_dst != 5'd0);
    assign same_reg  = (bus.ret_adr == bus.iss_dst);

    always_comb begin
        for (int i = 0; i < NREG; i++) cnt_nxt[i] = cnt[i];
        if (iss_fire & ~(ret_valid & same_reg))
            cnt_nxt[bus.iss_dst] = cnt[bus.iss_dst] + CNT_W'(1);
        if (ret_valid & ~(iss_fire & same_reg))
            cnt_nxt[bus.ret_adr] = cnt[bus.ret_adr] - CNT_W'(1);
        cnt_nxt[0] = '0;
    end

    // Underflowing retires never reach ret_valid, so the total is untouched by them.
    always_comb begin
        outstanding_nxt = outstanding_q;
        case ({iss_fire, ret_valid})
            2'b10:   outstanding_nxt = outstanding_q + TOT_W'(1);
            2'b01:   outstanding_nxt = outstanding_q - TOT_W'(1);
            default: outstanding_nxt = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            outstanding_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
            outstanding_q <= outstanding_nxt;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 1; i < NREG; i++) busy[i] = (cnt[i] != '0);
    end

    assign bus.iss_ready   = iss_ready;
    assign bus.stall       = bus.iss_valid & ~iss_ready;
    assign bus.busy_mask   = busy;
    assign bus.outstanding = outstanding_q;

`ifdef GRF_SCB_ERR_EN
    logic underflow;
    logic err_q;

    assign underflow = ret_fire & (cnt[bus.ret_adr] == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         err_q <= 1'b0;
        else if (underflow) err_q <= 1'b1;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && underflow) $display("SCB underflow @reg %d", bus.ret_adr);
    end
`endif

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: count-per-register model plus directed literal checks.
module tb_grf_scoreboard;
    localparam int MAXC = 3;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    grf_scoreboard_if #(.TOT_W(7)) bus ();

    grf_scoreboard #(.NREG(32), .CNT_W(2), .TOT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pending writes per register, total pending, sticky error.
    int m_cnt [32];
    int m_out;
    bit m_err;

    function automatic bit m_ret_fire();
        return bus.ret_we && !bus.pause && bus.ret_adr != 0;
    endfunction

    function automatic bit m_src_hazard(logic use_s, logic [4:0] s);
        if (!use_s || s == 0 || m_cnt[s] == 0) return 1'b0;
        if (m_ret_fire() && bus.ret_adr == s && m_cnt[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        bit full;
        full = bus.iss_dst != 0 && m_cnt[bus.iss_dst] == MAXC
               && !(m_ret_fire() && bus.ret_adr == bus.iss_dst);
        return !bus.pause && !m_src_hazard(bus.iss_use_rs, bus.iss_rs)
               && !m_src_hazard(bus.iss_use_rt, bus.iss_rt) && !full;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) b[i] = 1'b1;
        return b;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_out = 0;
            m_err = 0;
        end else begin
            int  pre_ret;
            bit  rf, isf;
            rf      = m_ret_fire();
            isf     = bus.iss_valid && m_ready() && bus.iss_dst != 0;
            pre_ret = m_cnt[bus.ret_adr];
            if (isf) begin
                m_cnt[bus.iss_dst] = m_cnt[bus.iss_dst] + 1;
                m_out = m_out + 1;
            end
            if (rf) begin
                if (pre_ret > 0) begin
                    m_cnt[bus.ret_adr] = m_cnt[bus.ret_adr] - 1;
                    m_out = m_out - 1;
                end else begin
`ifdef GRF_SCB_ERR_EN
                    m_err = 1;
`endif
                end
            end
        end
    end

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("iss_ready",   bus.iss_ready,   m_ready());
        check("stall",       bus.stall,       bus.iss_valid && !m_ready());
        check("busy_mask",   bus.busy_mask,   m_busy());
        check("outstanding", bus.outstanding, m_out);
        check("err",         bus.err,         m_err);
    end

    task automatic set_in(bit v, logic [4:0] d, logic [4:0] rs, bit urs,
                          logic [4:0] rt, bit urt, bit we, logic [4:0] a, bit p);
        bus.iss_valid  = v;
        bus.iss_dst    = d;
        bus.iss_rs     = rs;
        bus.iss_use_rs = urs;
        bus.iss_rt     = rt;
        bus.iss_use_rt = urt;
        bus.ret_we     = we;
        bus.ret_adr    = a;
        bus.pause      = p;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (3) tick();
        check("rst_outstanding", bus.outstanding, 0);
        check("rst_busy",        bus.busy_mask,   0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_ready",       bus.iss_ready,   1);
        check("rst_stall",       bus.stall,       0);
        idle();
        reset = 1'b1;
        tick();

        // Issue to r5, then a reader of r5 stalls.
        set_in(1, 5, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        check("busy5_set",   bus.busy_mask[5], 1);
        check("out_1",       bus.outstanding,  1);
        set_in(1, 0, 5, 1, 0, 0, 0, 0, 0);
        check("raw_stall",   bus.stall,        1);
        tick();
        // Same reader with a retire of r5 in the same cycle proceeds.
        set_in(1, 0, 5, 1, 0, 0, 1, 5, 0);
        check("fwd_ready",   bus.iss_ready,    1);
        tick();
        idle();
        check("busy5_clr",   bus.busy_mask[5], 0);
        check("out_0",       bus.outstanding,  0);

        // Fill r7 to the counter limit.
        repeat (3) begin
            set_in(1, 7, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        check("out_3",       bus.outstanding,  3);
        set_in(1, 7, 0, 0, 0, 0, 0, 0, 0);
        check("full_stall",  bus.stall,        1);
        tick();
        set_in(1, 7, 0, 0, 0, 0, 1, 7, 0);
        check("full_ret_rdy", bus.iss_ready,   1);
        tick();
        idle();
        check("out_still_3", bus.outstanding,  3);
        set_in(1, 7, 0, 0, 0, 0, 0, 0, 0);
        check("r7_still_full", bus.stall,      1);
        idle();

        // r9 at 2 with simultaneous issue and retire keeps its count.
        repeat (2) begin
            set_in(1, 9, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        set_in(1, 9, 0, 0, 0, 0, 1, 9, 0);
        tick();
        idle();
        check("out_5",       bus.outstanding,  5);
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0);
        tick();
        check("r9_one_left", bus.busy_mask[9], 1);
        tick();
        idle();
        check("r9_empty",    bus.busy_mask[9], 0);
        check("out_3b",      bus.outstanding,  3);

        // Retire of an idle register.
        set_in(0, 0, 0, 0, 0, 0, 1, 4, 0);
        tick();
        idle();
`ifdef GRF_SCB_ERR_EN
        check("underflow_err", bus.err,        1);
`else
        check("underflow_err", bus.err,        0);
`endif
        check("underflow_out", bus.outstanding, 3);

        // Pause freezes everything.
        set_in(1, 10, 0, 0, 0, 0, 1, 7, 1);
        check("pause_ready", bus.iss_ready,    0);
        repeat (3) tick();
        check("pause_out",   bus.outstanding,  3);
        check("pause_busy",  bus.busy_mask,    32'h0000_0080);
        idle();

        // Asynchronous reset mid-cycle with six outstanding.
        for (int r = 11; r <= 13; r++) begin
            set_in(1, 5'(r), 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        check("out_6",       bus.outstanding,  6);
        #2;
        reset = 1'b0;
        #1;
        check("async_out",   bus.outstanding,  0);
        check("async_busy",  bus.busy_mask,    0);
        tick();
        reset = 1'b1;
        tick();

        // Mixed traffic checked by the model on every cycle.
        for (int k = 0; k < 80; k++) begin
            logic [4:0] a;
            bit         we;
            a  = 5'($urandom_range(1, 7));
            we = (m_cnt[a] > 0) && ($urandom_range(0, 1) == 1);
            set_in(1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), we, a,
                   ($urandom_range(0, 7) == 0));
            tick();
        end
        idle();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
